// File: rtl/mem_wb_skid_reg_if.sv
// MEM->WB handshake bundle: upstream entry, downstream presented entry and the
// derived write-back controls.
interface mem_wb_skid_reg_if #(
    parameter int NBITS = 32,
    parameter int RBITS = 5
);
    logic             MEM_valid;
    logic             MEM_ready;
    logic [NBITS-1:0] MEM_result;
    logic [NBITS-1:0] MEM_data;
    logic [RBITS-1:0] MEM_rd;
    logic             MEM_regwrite;
    logic             MEM_memtoreg;
    logic             MEM_haltflag;

    logic             WB_ready;
    logic             WB_valid;
    logic [NBITS-1:0] WB_result;
    logic [NBITS-1:0] WB_data;
    logic [RBITS-1:0] WB_rd;
    logic             WB_memtoreg;
    logic             WB_haltflag;
    logic             WB_regwrite;
    logic [NBITS-1:0] WB_wdata;
    logic             WB_halted;

    // Environment side: produces MEM entries and consumes WB entries.
    modport master (
        output MEM_valid, MEM_result, MEM_data, MEM_rd,
               MEM_regwrite, MEM_memtoreg, MEM_haltflag, WB_ready,
        input  MEM_ready, WB_valid, WB_result, WB_data, WB_rd,
               WB_memtoreg, WB_haltflag, WB_regwrite, WB_wdata, WB_halted
    );

    // Pipeline register side.
    modport slave (
        input  MEM_valid, MEM_result, MEM_data, MEM_rd,
               MEM_regwrite, MEM_memtoreg, MEM_haltflag, WB_ready,
        output MEM_ready, WB_valid, WB_result, WB_data, WB_rd,
               WB_memtoreg, WB_haltflag, WB_regwrite, WB_wdata, WB_halted
    );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a one-entry skid buffer, flush, sticky halt
// and write-back data selection.
module mem_wb_skid_reg #(
    parameter int NBITS = 32,
    parameter int RBITS = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    mem_wb_skid_reg_if.slave    bus
);

    typedef struct packed {
        logic [NBITS-1:0] result;
        logic [NBITS-1:0] data;
        logic [RBITS-1:0] rd;
        logic             regwrite;
        logic             memtoreg;
        logic             haltflag;
    } entry_t;

    entry_t in_entry;
    entry_t out_reg;
    entry_t skid_reg;
    logic   out_valid_reg;
    logic   skid_valid_reg;
    logic   halted_reg;
    logic   mem_ready;
    logic   accept;
    logic   retire;

    assign in_entry.result   = bus.MEM_result;
    assign in_entry.data     = bus.MEM_data;
    assign in_entry.rd       = bus.MEM_rd;
    assign in_entry.regwrite = bus.MEM_regwrite;
    assign in_entry.memtoreg = bus.MEM_memtoreg;
    assign in_entry.haltflag = bus.MEM_haltflag;

    // Readiness depends only on registered state and flush, never on WB_ready,
    // so there is no combinational path from downstream back to upstream.
    assign mem_ready = !skid_valid_reg && !halted_reg && !i_flush;
    assign accept    = bus.MEM_valid && mem_ready;
    assign retire    = out_valid_reg && bus.WB_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            halted_reg     <= 1'b0;
            out_reg        <= '0;
            skid_reg       <= '0;
        end else if (i_flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            if (!out_valid_reg || retire) begin
                if (skid_valid_reg) begin
                    out_reg        <= skid_reg;
                    out_valid_reg  <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else if (accept) begin
                    out_reg        <= in_entry;
                    out_valid_reg  <= 1'b1;
                end else begin
                    out_valid_reg  <= 1'b0;
                end
            end else if (accept) begin
                skid_reg       <= in_entry;
                skid_valid_reg <= 1'b1;
            end
            if (retire && out_reg.haltflag) begin
                halted_reg <= 1'b1;
            end
        end
    end

    assign bus.MEM_ready   = mem_ready;
    assign bus.WB_valid    = out_valid_reg;
    assign bus.WB_result   = out_reg.result;
    assign bus.WB_data     = out_reg.data;
    assign bus.WB_rd       = out_reg.rd;
    assign bus.WB_memtoreg = out_reg.memtoreg;
    assign bus.WB_haltflag = out_reg.haltflag;
    // Register 0 is hardwired, so writes to it are suppressed here.
    assign bus.WB_regwrite = out_valid_reg && out_reg.regwrite && (out_reg.rd != '0);
    assign bus.WB_wdata    = out_reg.memtoreg ? out_reg.data : out_reg.result;
    assign bus.WB_halted   = halted_reg;

endmodule
